// File: rtl/ipod_pkg.sv
// ipod_pkg: shared FSM state type and default geometry for the playback sequencer
package ipod_pkg;
    localparam int DEF_ADDR_W = 23;
    localparam int DEF_SAMPLE_W = 16;
    localparam logic [DEF_ADDR_W-1:0] DEF_MAX_ADDRESS = 23'h7FFFF;
    typedef enum logic [2:0] {IDLE, REQ, WAIT_DATA, FIRST, WAIT2, SECOND, STOP} state_e;
endpackage

// File: rtl/flash_read_if.sv
// flash_read_if: single-outstanding flash read handshake and word capture
module flash_read_if #(
    parameter int ADDR_W = 23,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic              accept_o,
    output logic              word_vld_o,
    output logic [DATA_W-1:0] word_o,
    output logic              flash_read_o,
    output logic [ADDR_W-1:0] flash_address_o,
    input  logic              flash_waitrequest_i,
    input  logic              flash_readdatavalid_i,
    input  logic [DATA_W-1:0] flash_readdata_i
);
    logic read_q, read_d, wait_q, wait_d;
    logic [DATA_W-1:0] word_q, word_d;
    always_comb begin
        accept_o = read_q & ~flash_waitrequest_i;
        word_vld_o = wait_q & flash_readdatavalid_i;
        read_d = start_i | (read_q & flash_waitrequest_i);
        wait_d = accept_o | (wait_q & ~flash_readdatavalid_i);
        word_d = word_vld_o ? flash_readdata_i : word_q;
    end
    assign flash_read_o = read_q;
    assign flash_address_o = addr_i;
    assign word_o = word_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            read_q <= 1'b0;
            wait_q <= 1'b0;
            word_q <= '0;
        end else begin
            read_q <= read_d;
            wait_q <= wait_d;
            word_q <= word_d;
        end
    end
endmodule

// File: rtl/playback_sequencer.sv
// playback_sequencer: streams two samples per flash word at the audio tick rate
// PLAYBACK_LOOP_EN defined: wrap at song boundaries instead of stopping with done
module playback_sequencer import ipod_pkg::*; #(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] MAX_ADDRESS = DEF_MAX_ADDRESS,
    parameter int SAMPLE_W = DEF_SAMPLE_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sample_tick,
    input  logic                  play,
    input  logic                  direction,
    input  logic                  restart,
    output logic                  flash_read,
    output logic [ADDR_W-1:0]     flash_address,
    input  logic                  flash_waitrequest,
    input  logic                  flash_readdatavalid,
    input  logic [2*SAMPLE_W-1:0] flash_readdata,
    output logic [SAMPLE_W-1:0]   sample_out,
    output logic                  sample_valid,
    output logic                  done
);
`ifdef PLAYBACK_LOOP_EN
    localparam bit LOOP_EN = 1'b1;
`else
    localparam bit LOOP_EN = 1'b0;
`endif
    state_e state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d, addr_adv, addr_rld;
    logic [SAMPLE_W-1:0] sample_q, sample_d;
    logic [2*SAMPLE_W-1:0] word;
    logic dir_q, dir_d, restart_pending_q, restart_pending_d, done_q, done_d, valid_q, valid_d;
    logic start, accept, word_vld, at_end, go, reload;

    flash_read_if #(.ADDR_W(ADDR_W), .DATA_W(2*SAMPLE_W)) u_if (
        .clk                   (clk),
        .reset                 (reset),
        .start_i               (start),
        .addr_i                (addr_q),
        .accept_o              (accept),
        .word_vld_o            (word_vld),
        .word_o                (word),
        .flash_read_o          (flash_read),
        .flash_address_o       (flash_address),
        .flash_waitrequest_i   (flash_waitrequest),
        .flash_readdatavalid_i (flash_readdatavalid),
        .flash_readdata_i      (flash_readdata)
    );

    assign go = play & sample_tick;
    assign at_end = dir_q ? (addr_q == MAX_ADDRESS) : (addr_q == '0);
    assign addr_adv = dir_q ? (at_end ? '0 : addr_q + ADDR_W'(1)) : (at_end ? MAX_ADDRESS : addr_q - ADDR_W'(1));
    assign addr_rld = direction ? '0 : MAX_ADDRESS;
    // restart wins over a tick; a pending restart is honoured once the word's bus transfer is over
    assign reload = restart & (state_q == IDLE || state_q == WAIT2 || state_q == SECOND || state_q == STOP)
                  | (state_q == FIRST) & (restart_pending_q | restart);
    assign start = (state_q == IDLE) & go & ~restart;

    always_comb begin
        state_d = state_q;
        addr_d = addr_q;
        dir_d = dir_q;
        restart_pending_d = restart_pending_q;
        done_d = done_q;
        sample_d = sample_q;
        valid_d = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                dir_d = direction;
                state_d = REQ;
            end
            REQ: begin
                restart_pending_d = restart_pending_q | restart;
                state_d = accept ? WAIT_DATA : REQ;
            end
            WAIT_DATA: begin
                restart_pending_d = restart_pending_q | restart;
                if (word_vld) begin
                    state_d = FIRST;
                    valid_d = ~restart_pending_d;
                    sample_d = restart_pending_d ? sample_q : dir_q ? flash_readdata[SAMPLE_W-1:0] : flash_readdata[2*SAMPLE_W-1:SAMPLE_W];
                end
            end
            FIRST: state_d = WAIT2;
            WAIT2: if (go) begin
                state_d = SECOND;
                valid_d = 1'b1;
                sample_d = dir_q ? word[2*SAMPLE_W-1:SAMPLE_W] : word[SAMPLE_W-1:0];
            end
            SECOND: begin
                state_d = (at_end & ~LOOP_EN) ? STOP : IDLE;
                done_d = at_end & ~LOOP_EN;
                addr_d = (at_end & ~LOOP_EN) ? addr_q : addr_adv;
            end
            STOP: state_d = STOP;
            default: state_d = IDLE;
        endcase
        if (reload) begin
            state_d = IDLE;
            addr_d = addr_rld;
            done_d = 1'b0;
            restart_pending_d = 1'b0;
            valid_d = 1'b0;
            sample_d = sample_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q <= '0;
            dir_q <= 1'b1;
            restart_pending_q <= 1'b0;
            done_q <= 1'b0;
            sample_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q <= addr_d;
            dir_q <= dir_d;
            restart_pending_q <= restart_pending_d;
            done_q <= done_d;
            sample_q <= sample_d;
            valid_q <= valid_d;
        end
    end

    assign sample_out = sample_q;
    assign sample_valid = valid_q;
`ifdef PLAYBACK_LOOP_EN
    assign done = 1'b0;
`else
    assign done = done_q;
`endif
endmodule

// File: tb/tb_playback_sequencer.sv
// tb_playback_sequencer: random and directed playback against a sample-stream model
module tb_playback_sequencer;
    localparam logic [22:0] MAXA = 23'h7FFFF;
    logic clk = 0, reset = 1, sample_tick = 0, play = 0, direction = 1, restart = 0;
    logic flash_read, sample_valid, done;
    logic [22:0] flash_address;
    logic flash_waitrequest = 0, flash_readdatavalid = 0;
    logic [31:0] flash_readdata = 0;
    logic [15:0] sample_out;
    int n_chk = 0, n_fail = 0;
    int stall_left = 0, stall_max = 0, lat_min = 1, lat_max = 1, rd_cnt = 0;
    int n_acc = 0, n_rd = 0, n_stall = 0, n_sv = 0;
    logic was_stalled = 0;
    logic [22:0] req_addr = 0, rd_addr = 0;
    logic [22:0] exp_addr[$];
    logic [15:0] exp_samp[$];
    logic [22:0] maddr = 0;
    bit mhalf = 0, mdir = 1, mstop = 0;

    playback_sequencer dut (
        .clk                 (clk),
        .reset               (reset),
        .sample_tick         (sample_tick),
        .play                (play),
        .direction           (direction),
        .restart             (restart),
        .flash_read          (flash_read),
        .flash_address       (flash_address),
        .flash_waitrequest   (flash_waitrequest),
        .flash_readdatavalid (flash_readdatavalid),
        .flash_readdata      (flash_readdata),
        .sample_out          (sample_out),
        .sample_valid        (sample_valid),
        .done                (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem(input logic [22:0] a);
        return (a == 0) ? 32'hAAAA5555 : {a[15:0] ^ 16'h5A3C, a[15:0] + 16'h1357};
    endfunction

    // flash bus responder and output monitor, both away from the active edge
    always @(negedge clk) begin
        if (sample_valid) begin
            n_sv++;
            chk("sample_queued", exp_samp.size() != 0, 1);
            if (exp_samp.size() != 0) chk("sample", sample_out, exp_samp.pop_front());
        end
        flash_readdatavalid = 0;
        if (rd_cnt > 0) begin
            rd_cnt--;
            if (rd_cnt == 0) begin
                flash_readdatavalid = 1;
                flash_readdata = mem(rd_addr);
                n_rd++;
            end
        end
        if (flash_read) begin
            if (was_stalled) chk("stall_addr", flash_address, req_addr);
            req_addr = flash_address;
            if (stall_left > 0) begin
                flash_waitrequest = 1;
                stall_left--;
                n_stall++;
                was_stalled = 1;
            end else begin
                flash_waitrequest = 0;
                was_stalled = 0;
                n_acc++;
                chk("req_queued", exp_addr.size() != 0, 1);
                if (exp_addr.size() != 0) chk("req_addr", flash_address, exp_addr.pop_front());
                rd_addr = flash_address;
                rd_cnt = $urandom_range(lat_max, lat_min);
                stall_left = $urandom_range(stall_max, 0);
            end
        end else begin
            if (was_stalled) chk("read_held", flash_read, 1);
            was_stalled = 0;
            flash_waitrequest = 0;
        end
    end

    task automatic model_tick();
        logic [31:0] w;
        if (mstop || !play) return;
        w = mem(maddr);
        if (!mhalf) begin
            mdir = direction;
            exp_addr.push_back(maddr);
            exp_samp.push_back(mdir ? w[15:0] : w[31:16]);
            mhalf = 1;
        end else begin
            exp_samp.push_back(mdir ? w[31:16] : w[15:0]);
            mhalf = 0;
            if (mdir ? (maddr == MAXA) : (maddr == 0)) begin
`ifdef PLAYBACK_LOOP_EN
                maddr = mdir ? 23'd0 : MAXA;
`else
                mstop = 1;
`endif
            end else maddr = mdir ? maddr + 1 : maddr - 1;
        end
    endtask

    task automatic pulse();
        @(posedge clk); #1 sample_tick = 1;
        @(posedge clk); #1 sample_tick = 0;
    endtask

    task automatic do_tick(input bit p, input int gap);
        play = p;
        model_tick();
        pulse();
        repeat (gap) @(posedge clk);
        #1 chk("done", done, mstop);
    endtask

    task automatic do_restart();
        @(posedge clk); #1 restart = 1;
        @(posedge clk); #1 restart = 0;
        maddr = direction ? 23'd0 : MAXA;
        mhalf = 0;
        mstop = 0;
        repeat (2) @(posedge clk);
        #1 chk("done_clr", done, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k, a0, s0, v0, r0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_read", flash_read, 0);
        chk("rst_sample", sample_out, 0);
        chk("rst_valid", sample_valid, 0);
        chk("rst_done", done, 0);
        reset = 0;
        repeat (2) @(posedge clk);
        #1 direction = 1;
        play = 1;
        model_tick();
        pulse();
        k = 1;
        while (!sample_valid && k < 20) begin
            @(posedge clk); #1 k++;
        end
        chk("latency", k, 3);
        chk("first_sample", sample_out, 16'h5555);
        repeat (8) @(posedge clk);
        do_tick(1, 8);
        chk("second_sample", sample_out, 16'hAAAA);
        do_tick(1, 8);
        do_tick(1, 8);

        stall_left = 5;
        a0 = n_acc;
        s0 = n_stall;
        do_tick(1, 12);
        chk("stall_cycles", n_stall - s0, 5);
        chk("accepts", n_acc - a0, 1);
        do_tick(1, 8);

        do_tick(1, 8);
        v0 = n_sv;
        repeat (10) do_tick(0, 4);
        chk("pause_quiet", n_sv - v0, 0);
        do_tick(1, 8);
        chk("resume_sample", n_sv - v0, 1);

        direction = 1;
        do_restart();
        direction = 0;
        do_tick(1, 8);
        chk("back_first", sample_out, 16'hAAAA);
        do_tick(1, 8);
        chk("back_second", sample_out, 16'h5555);
        a0 = n_acc;
        do_tick(1, 8);
`ifdef PLAYBACK_LOOP_EN
        chk("post_boundary_req", n_acc - a0, 1);
`else
        chk("post_boundary_req", n_acc - a0, 0);
`endif
        do_tick(1, 8);
        direction = 1;
        do_restart();

        stall_max = 2;
        lat_max = 2;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(7, 0) == 0) direction = ~direction;
            if ($urandom_range(39, 0) == 0) do_restart();
            do_tick($urandom_range(3, 0) != 0, 8);
        end

        direction = 1;
        do_restart();
        repeat (512) do_tick(1, 8);
        stall_max = 0;
        stall_left = 0;
        lat_min = 3;
        lat_max = 3;
        exp_addr.push_back(maddr);
        a0 = n_acc;
        r0 = n_rd;
        v0 = n_sv;
        play = 1;
        pulse();
        for (int i = 0; i < 20 && n_acc == a0; i++) begin
            @(posedge clk); #2;
        end
        chk("accept_seen", n_acc - a0, 1);
        restart = 1;
        @(posedge clk); #1 restart = 0;
        maddr = 0;
        mhalf = 0;
        repeat (10) @(posedge clk);
        #1;
        chk("read_done", n_rd - r0, 1);
        chk("suppressed", n_sv - v0, 0);
        lat_min = 1;
        lat_max = 2;
        do_tick(1, 8);
        do_tick(1, 8);

        stall_max = 0;
        stall_left = 10;
        play = 1;
        pulse();
        for (int i = 0; i < 20 && !flash_read; i++) begin
            @(posedge clk); #2;
        end
        chk("read_up", flash_read, 1);
        reset = 1;
        #1;
        chk("rst_async_read", flash_read, 0);
        chk("rst_async_sample", sample_out, 0);
        chk("rst_async_valid", sample_valid, 0);
        stall_left = 0;
        was_stalled = 0;
        rd_cnt = 0;
        @(posedge clk); #1 reset = 0;
        maddr = 0;
        mhalf = 0;
        mdir = 1;
        mstop = 0;
        do_tick(1, 8);
        do_tick(1, 8);

        repeat (20) @(posedge clk);
        #1;
        chk("samp_drained", exp_samp.size(), 0);
        chk("req_drained", exp_addr.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
